// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the reg_file_ctrl register file.
// The optional write-protect feature is enabled with REG_FILE_CTRL_WPROT_EN.
package reg_file_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_NREGS  = 16;
   localparam int DEF_ADDR_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

endpackage

// File: rtl/reg_file_mem.sv
// NREGS x DATA_W register array: one write port, combinational read mux,
// contents cleared by reset and exported as a flat vector.
module reg_file_mem
   import reg_file_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NREGS  = DEF_NREGS,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                    clk,
   input  logic                    nRst,
   input  logic                    we,
   input  logic [ADDR_W-1:0]       waddr,
   input  logic [DATA_W-1:0]       wdata,
   input  logic [ADDR_W-1:0]       raddr,
   output logic [DATA_W-1:0]       rdata,
   output logic [NREGS*DATA_W-1:0] regs_q
);

   logic [DATA_W-1:0] mem_q [NREGS];
   logic [DATA_W-1:0] mem_d [NREGS];

   // Decoded per-entry compare keeps addresses beyond NREGS from touching anything.
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         mem_d[i] = mem_q[i];
         if (we && (waddr == ADDR_W'(i))) begin
            mem_d[i] = wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (raddr == ADDR_W'(i)) begin
            rdata = mem_q[i];
         end
      end
   end

   always_comb begin
      regs_q = '0;
      for (int i = 0; i < NREGS; i++) begin
         regs_q[i*DATA_W +: DATA_W] = mem_q[i];
      end
   end

endmodule

// File: rtl/reg_file_ctrl.sv
// Strobe-driven register file controller: address phase, data phase, valid/error.
// Define REG_FILE_CTRL_WPROT_EN to make registers flagged in RO_MASK read-only.
module reg_file_ctrl
   import reg_file_pkg::*;
#(
   parameter int               DATA_W  = DEF_DATA_W,
   parameter int               NREGS   = DEF_NREGS,
   parameter int               ADDR_W  = DEF_ADDR_W,
   parameter logic [NREGS-1:0] RO_MASK = '0
) (
   input  logic                    clk,
   input  logic                    nRst,
   input  logic [DATA_W-1:0]       data_in,
   input  logic                    read,
   input  logic                    write,
   output logic [DATA_W-1:0]       data_out,
   output logic                    valid,
   output logic                    error,
   output logic [NREGS*DATA_W-1:0] regs_q
);

   localparam logic [DATA_W:0] NREGS_EXT = (DATA_W+1)'(NREGS);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              range_err_q, range_err_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              valid_q, valid_d;
   logic              error_q, error_d;

   logic              we;
   logic [DATA_W-1:0] rdata;
   logic              wprot;
   logic              addr_oor;

   // Range check uses the whole bus so e.g. 0x10 is rejected rather than aliasing reg 0.
   assign addr_oor = ({1'b0, data_in} >= NREGS_EXT);

`ifdef REG_FILE_CTRL_WPROT_EN
   localparam logic [2**ADDR_W-1:0] RO_EXT = (2**ADDR_W)'(RO_MASK);
   assign wprot = RO_EXT[addr_q];
`else
   assign wprot = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      range_err_d = range_err_q;
      data_out_d  = data_out_q;
      valid_d     = 1'b0;
      error_d     = error_q;
      we          = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (read ^ write) begin
               addr_d      = data_in[ADDR_W-1:0];
               range_err_d = addr_oor;
               state_d     = read ? ST_READ : ST_WRITE;
            end
         end
         ST_READ: begin
            data_out_d = range_err_q ? '0 : rdata;
            error_d    = range_err_q;
            valid_d    = 1'b1;
            state_d    = ST_HOLD;
         end
         ST_WRITE: begin
            we      = !range_err_q && !wprot;
            error_d = range_err_q || wprot;
            valid_d = 1'b1;
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (!read && !write) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         range_err_q <= 1'b0;
         data_out_q  <= '0;
         valid_q     <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         range_err_q <= range_err_d;
         data_out_q  <= data_out_d;
         valid_q     <= valid_d;
         error_q     <= error_d;
      end
   end

   assign data_out = data_out_q;
   assign valid    = valid_q;
   assign error    = error_q;

   reg_file_mem #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk    (clk),
      .nRst   (nRst),
      .we     (we),
      .waddr  (addr_q),
      .wdata  (data_in),
      .raddr  (addr_q),
      .rdata  (rdata),
      .regs_q (regs_q)
   );

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Self-checking bench for reg_file_ctrl: vector table plus hand-written corner sequences,
// with a scoreboard matching every valid pulse against a queued expectation.
module tb_reg_file_ctrl;

   localparam int DATA_W = 8;
   localparam int NREGS  = 16;
   localparam int ADDR_W = 4;

`ifdef REG_FILE_CTRL_WPROT_EN
   localparam bit WP = 1'b1;
`else
   localparam bit WP = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    nRst;
   logic [DATA_W-1:0]       data_in;
   logic                    read;
   logic                    write;
   logic [DATA_W-1:0]       data_out;
   logic                    valid;
   logic                    error;
   logic [NREGS*DATA_W-1:0] regs_q;

   typedef struct {
      logic       is_write;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_do;
      logic       exp_err;
   } vec_t;

   typedef struct {
      logic [7:0] exp_do;
      logic       exp_err;
   } exp_t;

   vec_t vecs [12];
   exp_t sb_q [$];
   exp_t sb_e;

   int n_applied    = 0;
   int n_miscompare = 0;

   always #5 clk = ~clk;

   reg_file_ctrl #(
      .DATA_W  (DATA_W),
      .NREGS   (NREGS),
      .ADDR_W  (ADDR_W),
      .RO_MASK (16'h0001)
   ) dut (
      .clk      (clk),
      .nRst     (nRst),
      .data_in  (data_in),
      .read     (read),
      .write    (write),
      .data_out (data_out),
      .valid    (valid),
      .error    (error),
      .regs_q   (regs_q)
   );

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_miscompare++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (nRst === 1'b1 && valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            checkOutput("unexpected_valid", 128'd1, 128'd0);
         end else begin
            sb_e = sb_q.pop_front();
            checkOutput("sb_data_out", 128'(data_out), 128'(sb_e.exp_do));
            checkOutput("sb_error", 128'(error), 128'(sb_e.exp_err));
         end
      end
   end

   task automatic pushExp(input logic [7:0] exp_do, input logic exp_err);
      exp_t e;
      e.exp_do  = exp_do;
      e.exp_err = exp_err;
      sb_q.push_back(e);
   endtask

   // Called on a negedge with the DUT idle; returns on a negedge with the DUT idle again.
   task automatic applyStimulus(input logic is_write, input logic [7:0] addr, input logic [7:0] wdata,
                                input logic [7:0] exp_do, input logic exp_err);
      pushExp(exp_do, exp_err);
      data_in = addr;
      if (is_write) write = 1'b1;
      else          read  = 1'b1;
      @(negedge clk);
      data_in = wdata;
      read    = 1'b0;
      write   = 1'b0;
      @(negedge clk);
      checkOutput("valid_pulse", 128'(valid), 128'd1);
      @(negedge clk);
      checkOutput("valid_drop", 128'(valid), 128'd0);
   endtask

   initial begin
      logic [127:0] exp_regs;
      int           cnt;

      nRst    = 1'b0;
      read    = 1'b0;
      write   = 1'b0;
      data_in = '0;

      vecs[0]  = '{1'b0, 8'h03, 8'h00, 8'h00, 1'b0};
      vecs[1]  = '{1'b1, 8'h07, 8'hA5, 8'h00, 1'b0};
      vecs[2]  = '{1'b0, 8'h07, 8'h00, 8'hA5, 1'b0};
      vecs[3]  = '{1'b1, 8'h10, 8'h77, 8'hA5, 1'b1};
      vecs[4]  = '{1'b0, 8'h10, 8'h00, 8'h00, 1'b1};
      vecs[5]  = '{1'b1, 8'h0F, 8'h3C, 8'h00, 1'b0};
      vecs[6]  = '{1'b0, 8'h0F, 8'h00, 8'h3C, 1'b0};
      vecs[7]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[8]  = '{1'b1, 8'hFF, 8'h11, 8'h00, 1'b1};
      vecs[9]  = '{1'b0, 8'h07, 8'h00, 8'hA5, 1'b0};
      vecs[10] = '{1'b1, 8'h03, 8'hC3, 8'hA5, 1'b0};
      vecs[11] = '{1'b0, 8'h03, 8'h00, 8'hC3, 1'b0};

      repeat (3) @(negedge clk);
      checkOutput("reset_data_out", 128'(data_out), 128'd0);
      checkOutput("reset_valid", 128'(valid), 128'd0);
      checkOutput("reset_error", 128'(error), 128'd0);
      checkOutput("reset_regs", regs_q, 128'd0);
      nRst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].is_write, vecs[i].addr, vecs[i].wdata, vecs[i].exp_do, vecs[i].exp_err);
      end

      exp_regs            = '0;
      exp_regs[127:120]   = 8'h3C;
      exp_regs[63:56]     = 8'hA5;
      exp_regs[31:24]     = 8'hC3;
      checkOutput("regs_q_reg7", 128'(regs_q[63:56]), 128'hA5);
      checkOutput("regs_q_all", regs_q, exp_regs);

      // Read held high for 10 cycles: exactly one access.
      pushExp(8'hA5, 1'b0);
      data_in = 8'h07;
      read    = 1'b1;
      cnt     = 0;
      repeat (10) begin
         @(negedge clk);
         if (valid === 1'b1) cnt++;
      end
      checkOutput("held_read_pulses", 128'(cnt), 128'd1);
      read = 1'b0;
      @(negedge clk);

      // Both strobes together: no access at all.
      data_in = 8'h02;
      read    = 1'b1;
      write   = 1'b1;
      cnt     = 0;
      repeat (4) begin
         @(negedge clk);
         if (valid === 1'b1) cnt++;
      end
      checkOutput("both_strobes_pulses", 128'(cnt), 128'd0);
      read  = 1'b0;
      write = 1'b0;
      @(negedge clk);
      checkOutput("both_strobes_data_out", 128'(data_out), 128'hA5);

      // Write strobe swapped for read after the address phase: write still commits.
      pushExp(8'hA5, 1'b0);
      data_in = 8'h09;
      write   = 1'b1;
      @(negedge clk);
      write   = 1'b0;
      read    = 1'b1;
      data_in = 8'h66;
      @(negedge clk);
      checkOutput("swap_valid", 128'(valid), 128'd1);
      checkOutput("swap_reg9", 128'(regs_q[79:72]), 128'h66);
      repeat (3) @(negedge clk);
      checkOutput("swap_hold_no_repeat", 128'(valid), 128'd0);
      read = 1'b0;
      @(negedge clk);
      applyStimulus(1'b0, 8'h09, 8'h00, 8'h66, 1'b0);

      // Reset asserted during the WRITE cycle discards the access.
      data_in = 8'h0A;
      write   = 1'b1;
      @(negedge clk);
      data_in = 8'h99;
      write   = 1'b0;
      nRst    = 1'b0;
      #1;
      checkOutput("midreset_data_out", 128'(data_out), 128'd0);
      checkOutput("midreset_valid", 128'(valid), 128'd0);
      checkOutput("midreset_error", 128'(error), 128'd0);
      checkOutput("midreset_regs", regs_q, 128'd0);
      @(negedge clk);
      nRst = 1'b1;
      @(negedge clk);
      checkOutput("postreset_regs", regs_q, 128'd0);
      applyStimulus(1'b0, 8'h0A, 8'h00, 8'h00, 1'b0);

      // Write to register 0, which RO_MASK marks read-only.
      applyStimulus(1'b1, 8'h00, 8'h5A, 8'h00, WP);
      checkOutput("wprot_reg0", 128'(regs_q[7:0]), WP ? 128'h00 : 128'h5A);
      applyStimulus(1'b0, 8'h00, 8'h00, WP ? 8'h00 : 8'h5A, 1'b0);

      checkOutput("sb_drained", 128'(sb_q.size()), 128'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
      $finish;
   end

endmodule
